// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, opcode encodings and the
// canonical no-op word.
package cpu_pkg;

    localparam int DEFAULT_ADDR_W = 11;
    localparam int DEFAULT_DATA_W = 32;

    // Opcode lives in instr[31:29]
    localparam logic [2:0] LOAD     = 3'b111;
    localparam logic [2:0] STORE    = 3'b110;
    localparam logic [2:0] BRANCH   = 3'b101;
    localparam logic [2:0] ADD      = 3'b100;
    localparam logic [2:0] SUBTRACT = 3'b011;
    localparam logic [2:0] AND      = 3'b010;
    localparam logic [2:0] OR       = 3'b001;
    localparam logic [2:0] NOOP     = 3'b000;

    localparam logic [31:0] NOOP_INSTR = 32'h0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; simultaneous push and pop are
// both honoured, including push into a full FIFO that is popping.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is not reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads to instruction memory, buffers
// responses with their PC, and hands them to decode; redirects flush and drop.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W          = DEFAULT_ADDR_W,
    parameter int                DATA_W          = DEFAULT_DATA_W,
    parameter int                FIFO_DEPTH      = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int FIFO_W = ADDR_W + DATA_W;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [OCNT_W-1:0] live;
    logic [OCNT_W-1:0] drop;
    logic              issue;
    logic              rsp_drop;
    logic              rsp_live;

    logic [FIFO_W-1:0] fifo_rdata;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    logic [ADDR_W-1:0] pcq_head;
    logic [OCNT_W-1:0] pcq_count;
    logic              pcq_full;
    logic              pcq_empty;
    logic              pcq_pop;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        imem_req = 1'b0;
        rsp_drop = 1'b0;
        rsp_live = 1'b0;
        if (!reset) begin
            imem_req = !redirect_valid
                    && (int'(fifo_count) + int'(live) < FIFO_DEPTH)
                    && (int'(live) + int'(drop) < MAX_OUTSTANDING);
            // Stale reads are always older than live ones, so drops are consumed first
            rsp_drop = imem_rvalid && (drop != '0 || (redirect_valid && live != '0));
            rsp_live = imem_rvalid && !redirect_valid && drop == '0 && live != '0;
        end
    end

    assign imem_addr = reset ? RESET_PC : fetch_pc;
    assign issue     = imem_req && imem_gnt;
    assign pcq_pop   = rsp_drop || rsp_live;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            live     <= '0;
            drop     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_addr;
            live     <= '0;
            drop     <= drop + live + OCNT_W'(issue) - OCNT_W'(rsp_drop);
        end else begin
            if (issue) fetch_pc <= fetch_pc + 1'b1;
            live <= live + OCNT_W'(issue) - OCNT_W'(rsp_live);
            drop <= drop - OCNT_W'(rsp_drop);
        end
    end

    // Tracks the PC of every granted read, live or marked for drop
    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_pc_queue (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .push  (issue),
        .pop   (pcq_pop),
        .wdata (fetch_pc),
        .rdata (pcq_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    assign fifo_pop = instr_valid && instr_ready;

    sync_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_prefetch (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (rsp_live),
        .pop   (fifo_pop),
        .wdata ({pcq_head, imem_rdata}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign instr_valid = !reset && !fifo_empty;
    assign instr       = instr_valid ? fifo_rdata[DATA_W-1:0] : DATA_W'(NOOP_INSTR);
    assign instr_pc    = instr_valid ? fifo_rdata[FIFO_W-1 -: ADDR_W] : '0;

    a_rvalid_expected: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> (live != '0 || drop != '0));
    a_fifo_room: assert property (@(posedge clk) disable iff (reset)
        !(rsp_live && fifo_full && !fifo_pop));
    a_pcq_tracks: assert property (@(posedge clk) disable iff (reset)
        int'(pcq_count) == int'(live) + int'(drop));
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(issue && pcq_full));
    a_pcq_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pcq_pop && pcq_empty));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model whose read
// latency is selectable (1..3 cycles) and whose data is address*3.
module tb_fetch_unit;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    int checks = 0;
    int errors = 0;
    int lat    = 1;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(2), .RESET_PC('0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    // Memory model: fixed-latency pipeline, reset together with the DUT
    logic [2:0]        rsp_v;
    logic [DATA_W-1:0] rsp_d [3];

    always @(posedge clk) begin
        if (reset) rsp_v <= '0;
        else       rsp_v <= {rsp_v[1:0], imem_req & imem_gnt};
        rsp_d[0] <= 32'(imem_addr) * 32'd3;
        rsp_d[1] <= rsp_d[0];
        rsp_d[2] <= rsp_d[1];
    end

    assign imem_rvalid = rsp_v[lat-1];
    assign imem_rdata  = rsp_d[lat-1];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the last reset edge, reset released
    task automatic restart(input int latency, input logic ready);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        instr_ready    = ready;
        lat            = latency;
        step(2);
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (instr_valid !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 64'(instr_valid), 64'd1);
    endtask

    task automatic check_out(input string tag, input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] data);
        check({tag, "_valid"}, 64'(instr_valid), 64'd1);
        check({tag, "_pc"},    64'(instr_pc),    64'(pc));
        check({tag, "_instr"}, 64'(instr),       64'(data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        imem_gnt       = 1'b1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        instr_ready    = 1'b1;
        lat            = 1;

        // Reset state
        step(2);
        check("rst_req",   64'(imem_req),    64'd0);
        check("rst_addr",  64'(imem_addr),   64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr),       64'd0);
        check("rst_pc",    64'(instr_pc),    64'd0);

        // Streaming, 1-cycle memory, decode always ready
        reset = 1'b0;
        #1;
        check("s_req0",  64'(imem_req),  64'd1);
        check("s_addr0", 64'(imem_addr), 64'd0);
        step(1);
        check("s_addr1",  64'(imem_addr),   64'd1);
        check("s_valid1", 64'(instr_valid), 64'd0);
        step(1);
        check("s_addr2", 64'(imem_addr), 64'd2);
        check_out("s_out0", 11'd0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check_out("s_out", 11'(k), 32'(3 * k));
            check("s_addr", 64'(imem_addr), 64'(k + 2));
        end

        // Decode stalled from reset: FIFO fills with pc 0..3, then credit runs out
        restart(1, 1'b0);
        step(5);
        check("st_req_full",  64'(imem_req),  64'd0);
        check("st_addr_full", 64'(imem_addr), 64'd4);
        check_out("st_head", 11'd0, 32'd0);
        step(5);
        check("st_req_hold", 64'(imem_req), 64'd0);
        check_out("st_head_hold", 11'd0, 32'd0);
        instr_ready = 1'b1;
        #1;
        check("st_no_same_cycle_credit", 64'(imem_req), 64'd0);
        step(1);
        check_out("st_out1", 11'd1, 32'd3);
        check("st_req_resume",  64'(imem_req),  64'd1);
        check("st_addr_resume", 64'(imem_addr), 64'd4);
        step(1);
        check_out("st_out2", 11'd2, 32'd6);
        step(1);
        check_out("st_out3", 11'd3, 32'd9);
        step(1);
        check_out("st_out4", 11'd4, 32'd12);

        // Redirect with two reads outstanding and two buffered (3-cycle memory)
        restart(3, 1'b0);
        step(6);
        check("r_req_pre", 64'(imem_req), 64'd0);
        check_out("r_head_pre", 11'd0, 32'd0);
        redirect_valid = 1'b1;
        redirect_addr  = 11'h100;
        #1;
        check("r_req_redirect", 64'(imem_req), 64'd0);
        step(1);
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        #1;
        check("r_flushed",    64'(instr_valid), 64'd0);
        check("r_req_drop2",  64'(imem_req),    64'd0);
        step(1);
        check("r_stale_hidden", 64'(instr_valid), 64'd0);
        check("r_req_target",   64'(imem_req),    64'd1);
        check("r_addr_target",  64'(imem_addr),   64'h100);
        wait_valid("r_wait_target", 20);
        check_out("r_first", 11'h100, 32'h300);
        step(1);
        check_out("r_second", 11'h101, 32'h303);

        // Redirect in the same cycle as a response
        restart(1, 1'b1);
        step(3);
        check_out("rr_pre", 11'd1, 32'd3);
        redirect_valid = 1'b1;
        redirect_addr  = 11'h050;
        #1;
        check("rr_req_redirect", 64'(imem_req), 64'd0);
        step(1);
        redirect_valid = 1'b0;
        #1;
        check("rr_flushed",     64'(instr_valid), 64'd0);
        check("rr_req_target",  64'(imem_req),    64'd1);
        check("rr_addr_target", 64'(imem_addr),   64'h050);
        step(1);
        check("rr_stale_hidden", 64'(instr_valid), 64'd0);
        step(1);
        check_out("rr_first", 11'h050, 32'h0F0);

        // Back-to-back redirects, last one to 2046, then address wrap
        restart(1, 1'b1);
        redirect_valid = 1'b1;
        redirect_addr  = 11'h123;
        #1;
        check("w_req_redirect1", 64'(imem_req), 64'd0);
        step(1);
        redirect_addr = 11'd2046;
        #1;
        check("w_req_redirect2", 64'(imem_req), 64'd0);
        step(1);
        redirect_valid = 1'b0;
        #1;
        check("w_addr_2046", 64'(imem_addr), 64'd2046);
        step(1);
        check("w_addr_2047", 64'(imem_addr), 64'd2047);
        step(1);
        check("w_addr_0", 64'(imem_addr), 64'd0);
        check_out("w_out2046", 11'd2046, 32'd6138);
        step(1);
        check("w_addr_1", 64'(imem_addr), 64'd1);
        check_out("w_out2047", 11'd2047, 32'd6141);
        step(1);
        check_out("w_out0", 11'd0, 32'd0);
        step(1);
        check_out("w_out1", 11'd1, 32'd3);

        // Reset mid-stream with a full FIFO (pre-reset stream starts at 0x200)
        restart(1, 1'b0);
        redirect_valid = 1'b1;
        redirect_addr  = 11'h200;
        step(1);
        redirect_valid = 1'b0;
        #1;
        check("mr_addr_start", 64'(imem_addr), 64'h200);
        step(8);
        check("mr_req_full", 64'(imem_req), 64'd0);
        check_out("mr_head", 11'h200, 32'h600);
        reset = 1'b1;
        #1;
        check("mr_rst_req",   64'(imem_req),    64'd0);
        check("mr_rst_addr",  64'(imem_addr),   64'd0);
        check("mr_rst_valid", 64'(instr_valid), 64'd0);
        check("mr_rst_instr", 64'(instr),       64'd0);
        check("mr_rst_pc",    64'(instr_pc),    64'd0);
        step(1);
        reset       = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("mr_req_after",   64'(imem_req),    64'd1);
        check("mr_addr_after",  64'(imem_addr),   64'd0);
        check("mr_valid_after", 64'(instr_valid), 64'd0);
        step(1);
        check("mr_no_old_data", 64'(instr_valid), 64'd0);
        step(1);
        check_out("mr_first", 11'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
